// File: rtl/lfsr_random_gen_param.sv
// Galois-LFSR pseudo-random source with bounded draws in [0, LIMIT] via REQ/VALID.
// Rejection sampling with a retry cap, run-time reseeding and all-zero lock-up recovery.
module lfsr_random_gen_param #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'h6B8E,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'h5D09,
  parameter int               OUT_WIDTH    = 8,
  parameter int               MAX_TRIES    = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 SEED_LOAD,
  input  logic [WIDTH-1:0]     SEED_IN,
  input  logic                 REQ,
  input  logic [OUT_WIDTH-1:0] LIMIT,
  output logic [WIDTH-1:0]     RAW,
  output logic [OUT_WIDTH-1:0] RAND_OUT,
  output logic                 VALID,
  output logic                 BUSY
);

  localparam int TW = $clog2(MAX_TRIES + 1);

  typedef enum logic {
    ST_IDLE,
    ST_DRAW
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     lfsr_q, lfsr_d;
  logic [OUT_WIDTH-1:0] limit_q, limit_d;
  logic [OUT_WIDTH-1:0] mask_q, mask_d;
  logic [TW-1:0]        tries_q, tries_d;
  logic [OUT_WIDTH-1:0] rand_q, rand_d;
  logic                 valid_q, valid_d;

  logic [OUT_WIDTH-1:0] cand;
  logic [TW-1:0]        tries_inc;

  // Bit 0 always receives the outgoing MSB; TAPS[0] has no effect.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] fb;
    fb = s[WIDTH-1] ? {TAPS[WIDTH-1:1], 1'b0} : '0;
    return {s[WIDTH-2:0], s[WIDTH-1]} ^ fb;
  endfunction

  // Smear the leading one downwards: smallest 2^k-1 covering lim.
  function automatic logic [OUT_WIDTH-1:0] mask_of(input logic [OUT_WIDTH-1:0] lim);
    logic [OUT_WIDTH-1:0] m;
    m = lim;
    for (int i = 1; i < OUT_WIDTH; i++) begin
      m = m | (m >> i);
    end
    return m;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    limit_d   = limit_q;
    mask_d    = mask_q;
    tries_d   = tries_q;
    rand_d    = rand_q;
    valid_d   = 1'b0;
    cand      = lfsr_q[OUT_WIDTH-1:0] & mask_q;
    tries_inc = tries_q + 1'b1;

    if (SEED_LOAD) begin
      lfsr_d  = (SEED_IN == '0) ? DEFAULT_SEED : SEED_IN;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (REQ) begin
            limit_d = LIMIT;
            mask_d  = mask_of(LIMIT);
            tries_d = '0;
            state_d = ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (cand <= limit_q) begin
            rand_d  = cand;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else if (tries_inc == TW'(MAX_TRIES)) begin
            // cand <= mask <= 2*limit+1, so the fold-down lands inside [0, limit].
            rand_d  = cand - limit_q - 1'b1;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tries_d = tries_inc;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (lfsr_q == '0) begin
        lfsr_d = DEFAULT_SEED;
      end else if (state_q == ST_DRAW || EN) begin
        lfsr_d = lfsr_step(lfsr_q);
      end
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (RST) begin
      state_q <= ST_IDLE;
      lfsr_q  <= DEFAULT_SEED;
      limit_q <= '0;
      mask_q  <= '0;
      tries_q <= '0;
      rand_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      limit_q <= limit_d;
      mask_q  <= mask_d;
      tries_q <= tries_d;
      rand_q  <= rand_d;
      valid_q <= valid_d;
    end
  end

  assign RAW      = lfsr_q;
  assign RAND_OUT = rand_q;
  assign VALID    = valid_q;
  assign BUSY     = (state_q == ST_DRAW);

endmodule

// File: tb/tb_lfsr_random_gen_param.sv
// Scoreboard bench for lfsr_random_gen_param: a transaction-level model predicts every
// bounded draw (value and arrival edge) and a separate monitor checks VALID/RAND_OUT.
module tb_lfsr_random_gen_param;

  localparam int          MT   = 8;
  localparam logic [15:0] TAPS = 16'h6B8E;
  localparam logic [15:0] DEF  = 16'h5D09;

  logic        CLK = 1'b0;
  logic        RST, EN, SEED_LOAD, REQ;
  logic [15:0] SEED_IN;
  logic [7:0]  LIMIT;
  logic [15:0] RAW;
  logic [7:0]  RAND_OUT;
  logic        VALID, BUSY;

  lfsr_random_gen_param dut (
    .CLK(CLK), .RST(RST), .EN(EN), .SEED_LOAD(SEED_LOAD), .SEED_IN(SEED_IN),
    .REQ(REQ), .LIMIT(LIMIT), .RAW(RAW), .RAND_OUT(RAND_OUT), .VALID(VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] val;
    int         edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic [15:0] m_lfsr;
  bit          m_active;
  int          m_end;
  logic [7:0]  m_val, m_last;
  int          m_accepts;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Multiply the state polynomial by x modulo the feedback polynomial.
  function automatic logic [15:0] ref_mulx(input logic [15:0] s);
    int v;
    v = int'(s) * 2;
    if (v >= 65536) v = (v - 65536) ^ (int'(TAPS) | 1);
    return 16'(v);
  endfunction

  function automatic int mask_for(input int lim);
    int m;
    m = 0;
    while (m < lim) m = m * 2 + 1;
    return m;
  endfunction

  // Full outcome of one draw starting from state s1: value and number of draw cycles.
  task automatic outcome(input logic [15:0] s1, input int lim, output logic [7:0] val,
                         output int k);
    int          mask, c;
    logic [15:0] s;
    mask = mask_for(lim);
    s    = s1;
    val  = '0;
    k    = MT;
    for (int t = 1; t <= MT; t++) begin
      c = (int'(s) % 256) & mask;
      if (c <= lim) begin
        val = 8'(c);
        k   = t;
        return;
      end
      if (t == MT) begin
        val = 8'(c - lim - 1);
        k   = t;
        return;
      end
      s = ref_mulx(s);
    end
  endtask

  task automatic model_edge(input logic en, input logic sl, input logic [15:0] seed,
                            input logic rq, input logic [7:0] lim);
    logic [15:0] nxt;
    bit          busy_now;
    int          k;
    exp_t        e;
    busy_now = m_active;
    if (sl) begin
      nxt = (seed == 16'h0) ? DEF : seed;
      if (m_active) begin
        m_active = 1'b0;
        void'(exp_q.pop_back());
      end
    end else begin
      if (m_lfsr == 16'h0)    nxt = DEF;
      else if (busy_now || en) nxt = ref_mulx(m_lfsr);
      else                     nxt = m_lfsr;
      if (busy_now) begin
        if (cyc == m_end) begin
          m_active = 1'b0;
          m_last   = m_val;
        end
      end else if (rq) begin
        outcome(nxt, int'(lim), m_val, k);
        m_active = 1'b1;
        m_end    = cyc + k;
        e.val    = m_val;
        e.edge_n = cyc + k;
        exp_q.push_back(e);
        m_accepts++;
      end
    end
    m_lfsr = nxt;
  endtask

  task automatic cycle(input logic en, input logic sl, input logic [15:0] seed,
                       input logic rq, input logic [7:0] lim);
    EN        = en;
    SEED_LOAD = sl;
    SEED_IN   = seed;
    REQ       = rq;
    LIMIT     = lim;
    @(posedge CLK);
    cyc++;
    model_edge(en, sl, seed, rq, lim);
    @(negedge CLK);
    check("raw", 32'(RAW), 32'(m_lfsr));
    check("busy", 32'(BUSY), 32'(m_active));
    check("rand_hold", 32'(RAND_OUT), 32'(m_last));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 8'h0);
  endtask

  function automatic logic [7:0] pick_limit();
    case ($urandom_range(0, 5))
      0:       return 8'd0;
      1:       return 8'd1;
      2:       return 8'd128;
      3:       return 8'd255;
      4:       return 8'($urandom_range(128, 140));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Monitor: VALID must appear exactly on predicted edges, carrying the predicted value.
  always @(negedge CLK) begin : monitor
    bit   exp_v;
    exp_t e;
    if (RST === 1'b0) begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].edge_n == cyc);
      check("valid", 32'(VALID), 32'(exp_v));
      if (exp_v) begin
        e = exp_q.pop_front();
        if (VALID) check("rand_out", 32'(RAND_OUT), 32'(e.val));
      end
    end
  end

  initial begin : stim
    int first_ret, start, guard;
    bit zero_seen;
    logic [7:0] saved;

    RST = 1'b1; EN = 1'b0; SEED_LOAD = 1'b0; SEED_IN = '0; REQ = 1'b0; LIMIT = '0;
    m_lfsr = DEF; m_active = 1'b0; m_end = 0; m_val = '0; m_last = '0; m_accepts = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check("rst_raw", 32'(RAW), 32'(16'h5D09));
    check("rst_rand", 32'(RAND_OUT), 32'h0);
    check("rst_valid", 32'(VALID), 32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);

    cycle(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    check("t1_step1", 32'(RAW), 32'(16'hBA12));
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    check("t1_step2", 32'(RAW), 32'(16'h1FAB));
    idle();
    check("t1_hold", 32'(RAW), 32'(16'h1FAB));

    cycle(1'b0, 1'b1, DEF, 1'b0, 8'h0);
    first_ret = 0;
    zero_seen = 1'b0;
    for (int i = 1; i <= 65535; i++) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
      if (RAW == DEF && first_ret == 0) first_ret = i;
      if (RAW == 16'h0) zero_seen = 1'b1;
    end
    check("t2_period", 32'(first_ret), 32'd65535);
    check("t2_never_zero", 32'(zero_seen), 32'h0);

    cycle(1'b1, 1'b1, 16'h0000, 1'b0, 8'h0);
    check("t3_zero_seed", 32'(RAW), 32'(16'h5D09));
    cycle(1'b0, 1'b1, 16'h0001, 1'b0, 8'h0);
    check("t3_seed1", 32'(RAW), 32'(16'h0001));
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    check("t3_seed1_step", 32'(RAW), 32'(16'h0002));

    cycle(1'b0, 1'b0, 16'h0, 1'b1, 8'd0);
    check("t4_busy", 32'(BUSY), 32'h1);
    check("t4_no_valid_yet", 32'(VALID), 32'h0);
    idle();
    check("t4_valid", 32'(VALID), 32'h1);
    check("t4_rand", 32'(RAND_OUT), 32'h0);
    check("t4_busy_low", 32'(BUSY), 32'h0);

    start = m_accepts;
    guard = 0;
    while (m_accepts - start < 1000 && guard < 20000) begin
      cycle(1'($urandom_range(0, 1)), 1'b0, 16'h0, 1'($urandom_range(0, 1)), 8'd9);
      guard++;
    end
    check("t5_accepts", 32'(m_accepts - start), 32'd1000);

    start = m_accepts;
    guard = 0;
    while (m_accepts - start < 400 && guard < 12000) begin
      cycle(1'($urandom_range(0, 1)), 1'b0, 16'h0, 1'($urandom_range(0, 1)), pick_limit());
      guard++;
    end
    check("t5b_accepts", 32'(m_accepts - start), 32'd400);

    guard = 0;
    while (m_active && guard < 20) begin
      idle();
      guard++;
    end
    saved = RAND_OUT;
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 8'd200);
    check("t6_busy", 32'(BUSY), 32'h1);
    cycle(1'b0, 1'b1, 16'h1234, 1'b1, 8'd7);
    check("t6_abort_busy", 32'(BUSY), 32'h0);
    check("t6_abort_valid", 32'(VALID), 32'h0);
    check("t6_abort_rand", 32'(RAND_OUT), 32'(saved));
    check("t6_abort_raw", 32'(RAW), 32'(16'h1234));
    repeat (4) idle();
    cycle(1'b0, 1'b1, 16'hBEEF, 1'b1, 8'd3);
    check("t6_req_dropped", 32'(BUSY), 32'h0);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 8'd200);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 8'd0);
    cycle(1'b1, 1'b0, 16'h0, 1'b1, 8'd0);

    repeat (12) idle();
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
